// File: rtl/dealer_sequencer_if.sv
// Handshake and result bundle between a dealer_sequencer and its controller/card source.
// The master drives requests and cards; the slave (the sequencer) drives status and results.
interface dealer_sequencer_if;
  logic       start;
  logic [5:0] player_score;
  logic       card_req;
  logic       card_ack;
  logic [3:0] card_in;
  logic [5:0] dealer_score;
  logic [3:0] cards_drawn;
  logic       busy;
  logic       done;
  logic [1:0] outcome;

  modport master (
    output start, player_score, card_ack, card_in,
    input  card_req, dealer_score, cards_drawn, busy, done, outcome
  );

  modport slave (
    input  start, player_score, card_ack, card_in,
    output card_req, dealer_score, cards_drawn, busy, done, outcome
  );
endinterface

// File: rtl/dealer_sequencer.sv
// Dealer turn sequencer: draws cards until stand/bust/card cap, then scores against the player.
// Per card: REQ (held until card_ack) -> ADD -> CHECK, so at least 3 cycles per card.
module dealer_sequencer #(
  parameter int STAND_AT   = 17,
  parameter int BUST_LIMIT = 21,
  parameter int MAX_CARDS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  dealer_sequencer_if.slave dif
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADD, S_CHECK, S_DONE} state_t;

  localparam logic [5:0] STAND_V = 6'(STAND_AT);
  localparam logic [5:0] BUST_V  = 6'(BUST_LIMIT);
  localparam logic [3:0] MAXC_V  = 4'(MAX_CARDS);

  state_t     state_q, state_d;
  logic [5:0] player_q, player_d;
  logic [5:0] score_q, score_d;
  logic [3:0] card_q, card_d;
  logic [3:0] cards_q, cards_d;
  logic [1:0] outcome_q, outcome_d;

  function automatic logic [5:0] card_value(input logic [3:0] c);
    return (c > 4'd10) ? 6'd10 : {2'b00, c};
  endfunction

  // 01 player wins, 10 dealer wins, 11 push
  function automatic logic [1:0] judge(input logic [5:0] p, input logic [5:0] d);
    if (p > BUST_V)      return 2'b10;
    else if (d > BUST_V) return 2'b01;
    else if (d > p)      return 2'b10;
    else if (d < p)      return 2'b01;
    else                 return 2'b11;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      player_q  <= 6'd0;
      score_q   <= 6'd0;
      card_q    <= 4'd0;
      cards_q   <= 4'd0;
      outcome_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      player_q  <= player_d;
      score_q   <= score_d;
      card_q    <= card_d;
      cards_q   <= cards_d;
      outcome_q <= outcome_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    player_d  = player_q;
    score_d   = score_q;
    card_d    = card_q;
    cards_d   = cards_q;
    outcome_d = outcome_q;
    case (state_q)
      S_IDLE: begin
        if (dif.start) begin
          player_d  = dif.player_score;
          score_d   = 6'd0;
          cards_d   = 4'd0;
          outcome_d = 2'b00;
          if (dif.player_score > BUST_V) begin
            state_d   = S_DONE;
            outcome_d = 2'b10;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A zero card is illegal: drop it and keep requesting
        if (dif.card_ack && (dif.card_in != 4'd0)) begin
          card_d  = dif.card_in;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        score_d = score_q + card_value(card_q);
        cards_d = cards_q + 4'd1;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if ((score_q >= STAND_V) || (score_q > BUST_V) || (cards_q == MAXC_V)) begin
          state_d   = S_DONE;
          outcome_d = judge(player_q, score_q);
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign dif.card_req     = (state_q == S_REQ);
  assign dif.busy         = (state_q != S_IDLE);
  assign dif.done         = (state_q == S_DONE);
  assign dif.dealer_score = score_q;
  assign dif.cards_drawn  = cards_q;
  assign dif.outcome      = outcome_q;
endmodule

// File: tb/tb_dealer_sequencer.sv
// Directed bench: a table of complete dealer turns plus hand-written sequences for
// illegal cards, the card cap, starts while busy and reset mid-turn.
module tb_dealer_sequencer;
  logic clock;
  logic reset;

  dealer_sequencer_if m ();
  dealer_sequencer_if s ();

  dealer_sequencer dut (
    .clock (clock),
    .reset (reset),
    .dif   (m)
  );

  dealer_sequencer #(.MAX_CARDS(2)) dut_cap2 (
    .clock (clock),
    .reset (reset),
    .dif   (s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [5:0]       player;
    int               ncards;
    logic [4:0][3:0]  cards;
    int               delay;
    logic [5:0]       exp_score;
    logic [3:0]       exp_cards;
    logic [1:0]       exp_out;
    int               exp_done_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mkv(input logic [5:0] p, input int n,
                               input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                               input logic [3:0] c3, input logic [3:0] c4, input int dly,
                               input logic [5:0] sc, input logic [3:0] nc, input logic [1:0] oc,
                               input int dcyc);
    vec_t v;
    v.player       = p;
    v.ncards       = n;
    v.cards        = {c4, c3, c2, c1, c0};
    v.delay        = dly;
    v.exp_score    = sc;
    v.exp_cards    = nc;
    v.exp_out      = oc;
    v.exp_done_cyc = dcyc;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int k, wait_c, cyc, req_cnt, first_req, done_cyc;
    k = 0; wait_c = 0; req_cnt = 0; first_req = -1; done_cyc = -1;
    m.player_score = v.player;
    m.start = 1'b1;
    tick();
    m.start = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 300) begin
      m.card_ack = 1'b0;
      if (m.done) begin
        done_cyc = cyc;
      end else begin
        if (m.card_req) begin
          req_cnt++;
          if (first_req < 0) first_req = cyc;
          if (wait_c == v.delay) begin
            m.card_ack = 1'b1;
            m.card_in  = (k < 5) ? v.cards[k] : 4'd10;
            k++;
            wait_c = 0;
          end else begin
            wait_c++;
          end
        end
        tick();
        cyc++;
      end
    end
    m.card_ack = 1'b0;
    check($sformatf("v%0d done_cycle", idx), done_cyc, v.exp_done_cyc);
    check($sformatf("v%0d first_req_cycle", idx), first_req, (v.ncards == 0) ? -1 : 1);
    check($sformatf("v%0d card_req_cycles", idx), req_cnt, v.ncards * (v.delay + 1));
    check($sformatf("v%0d dealer_score", idx), int'(m.dealer_score), int'(v.exp_score));
    check($sformatf("v%0d cards_drawn", idx), int'(m.cards_drawn), int'(v.exp_cards));
    check($sformatf("v%0d outcome", idx), int'(m.outcome), int'(v.exp_out));
    check($sformatf("v%0d busy_at_done", idx), int'(m.busy), 1);
    tick();
    check($sformatf("v%0d done_one_cycle", idx), int'(m.done), 0);
    check($sformatf("v%0d idle_after_done", idx), int'(m.busy), 0);
    check($sformatf("v%0d score_held", idx), int'(m.dealer_score), int'(v.exp_score));
    check($sformatf("v%0d outcome_held", idx), int'(m.outcome), int'(v.exp_out));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_seen;
    // player, n, cards[0..4], delay, score, cards, outcome, done cycle
    vecs[0] = mkv(6'd18, 2, 4'd10, 4'd7, 4'd0, 4'd0, 4'd0, 0, 6'd17, 4'd2, 2'b01, 7);
    vecs[1] = mkv(6'd20, 3, 4'd10, 4'd6, 4'd9, 4'd0, 4'd0, 0, 6'd25, 4'd3, 2'b01, 10);
    vecs[2] = mkv(6'd16, 2, 4'd12, 4'd8, 4'd0, 4'd0, 4'd0, 0, 6'd18, 4'd2, 2'b10, 7);
    vecs[3] = mkv(6'd22, 0, 4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 0, 6'd0,  4'd0, 2'b10, 1);
    vecs[4] = mkv(6'd19, 2, 4'd13, 4'd9, 4'd0, 4'd0, 4'd0, 5, 6'd19, 4'd2, 2'b11, 17);
    vecs[5] = mkv(6'd10, 5, 4'd2,  4'd3, 4'd4, 4'd5, 4'd6, 0, 6'd20, 4'd5, 2'b10, 16);

    reset = 1'b1;
    m.start = 1'b0; m.player_score = 6'd0; m.card_ack = 1'b0; m.card_in = 4'd0;
    s.start = 1'b0; s.player_score = 6'd0; s.card_ack = 1'b0; s.card_in = 4'd0;
    repeat (3) tick();
    check("rst card_req", int'(m.card_req), 0);
    check("rst busy", int'(m.busy), 0);
    check("rst done", int'(m.done), 0);
    check("rst dealer_score", int'(m.dealer_score), 0);
    check("rst cards_drawn", int'(m.cards_drawn), 0);
    check("rst outcome", int'(m.outcome), 0);
    check("rst cap2 busy", int'(s.busy), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Cap of two cards, with an illegal zero card acked first
    s.player_score = 6'd15; s.start = 1'b1;
    tick(); s.start = 1'b0;
    check("cap2 c1 card_req", int'(s.card_req), 1);
    s.card_ack = 1'b1; s.card_in = 4'd0;
    tick();
    check("cap2 zero card_req_held", int'(s.card_req), 1);
    check("cap2 zero cards_drawn", int'(s.cards_drawn), 0);
    check("cap2 zero score", int'(s.dealer_score), 0);
    s.card_in = 4'd5;
    tick(); s.card_ack = 1'b0;
    check("cap2 add card_req", int'(s.card_req), 0);
    tick();
    check("cap2 check score", int'(s.dealer_score), 5);
    check("cap2 check cards", int'(s.cards_drawn), 1);
    tick();
    check("cap2 second req", int'(s.card_req), 1);
    s.card_ack = 1'b1; s.card_in = 4'd5;
    tick(); s.card_ack = 1'b0;
    tick();
    tick();
    check("cap2 done", int'(s.done), 1);
    check("cap2 score", int'(s.dealer_score), 10);
    check("cap2 cards", int'(s.cards_drawn), 2);
    check("cap2 outcome", int'(s.outcome), 1);
    tick();
    check("cap2 idle", int'(s.busy), 0);

    // Starts with a different player score while busy must not restart or relatch
    m.player_score = 6'd18; m.start = 1'b1;
    tick();
    m.player_score = 6'd5;
    tick();
    check("busy_start still req", int'(m.card_req), 1);
    m.start = 1'b0; m.card_ack = 1'b1; m.card_in = 4'd10;
    tick(); m.card_ack = 1'b0; m.start = 1'b1;
    tick(); m.start = 1'b0;
    tick();
    check("busy_start score kept", int'(m.dealer_score), 10);
    check("busy_start req again", int'(m.card_req), 1);
    m.card_ack = 1'b1; m.card_in = 4'd8;
    tick(); m.card_ack = 1'b0;
    tick(); tick();
    check("busy_start done", int'(m.done), 1);
    check("busy_start outcome push", int'(m.outcome), 3);
    check("busy_start score", int'(m.dealer_score), 18);
    tick();

    // Start held high through the DONE cycle of a player-bust turn is ignored there
    m.player_score = 6'd22; m.start = 1'b1;
    tick();
    check("bust_hold done", int'(m.done), 1);
    check("bust_hold card_req", int'(m.card_req), 0);
    tick();
    check("bust_hold idle", int'(m.busy), 0);
    check("bust_hold done_low", int'(m.done), 0);
    m.start = 1'b0;
    tick();

    // Reset mid-turn while card_req is high, with start and card_ack also asserted
    m.player_score = 6'd18; m.start = 1'b1;
    tick(); m.start = 1'b0;
    m.card_ack = 1'b1; m.card_in = 4'd10;
    tick(); m.card_ack = 1'b0;
    tick(); tick();
    check("rst_mid req_high", int'(m.card_req), 1);
    check("rst_mid score before", int'(m.dealer_score), 10);
    reset = 1'b1; m.start = 1'b1; m.card_ack = 1'b1; m.card_in = 4'd7;
    tick();
    reset = 1'b0; m.start = 1'b0; m.card_ack = 1'b0;
    check("rst_mid card_req", int'(m.card_req), 0);
    check("rst_mid busy", int'(m.busy), 0);
    check("rst_mid done", int'(m.done), 0);
    check("rst_mid dealer_score", int'(m.dealer_score), 0);
    check("rst_mid cards_drawn", int'(m.cards_drawn), 0);
    check("rst_mid outcome", int'(m.outcome), 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m.done || m.busy) done_seen++;
    end
    check("rst_mid no done/busy after", done_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
